// File: rtl/store_checker.sv
// store_checker: checks CPU stores against a preloaded table of expected
// (address, data, mask) entries, in load order, and reports pass/fail/timeout.
// Optional build macro STORE_CHECKER_FILTER_EN: stores to an address other than
// the currently expected one are ignored instead of causing a failure.
module store_checker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               memwrite,
  input  logic [ADDR_W-1:0]        dataadr,
  input  logic [DATA_W-1:0]        writedata,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic [DATA_W-1:0]        ld_mask,
  input  logic                     start,
  input  logic                     clear,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [$clog2(DEPTH):0]   match_cnt,
  output logic                     ld_ovf
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [IW:0]   ONE    = 1;
  localparam logic [TW-1:0] T_ONE  = 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [IW:0]       wr_ptr;
  logic [TW-1:0]     tcnt;

  logic [ADDR_W-1:0] exp_addr [DEPTH];
  logic [DATA_W-1:0] exp_data [DEPTH];
  logic [DATA_W-1:0] exp_mask [DEPTH];

  logic          table_full;
  logic          ld_accept;
  logic [IW-1:0] rd_idx;
  logic [IW:0]   next_cnt;
  logic          store;
  logic          addr_hit;
  logic          data_hit;
  logic          store_hit;
  logic          store_bad;

  // DEPTH is a power of two, so the count's top bit alone marks a full table
  assign table_full = wr_ptr[IW];
  assign ld_accept  = (state == S_IDLE) && ld_valid && !table_full;
  assign rd_idx     = match_cnt[IW-1:0];
  assign next_cnt   = match_cnt + ONE;
  assign store      = |memwrite;
  assign addr_hit   = (dataadr == exp_addr[rd_idx]);
  assign data_hit   = ((writedata ^ exp_data[rd_idx]) & exp_mask[rd_idx]) == '0;
  assign store_hit  = store && addr_hit && data_hit;

`ifdef STORE_CHECKER_FILTER_EN
  assign store_bad  = store && addr_hit && !data_hit;
`else
  assign store_bad  = store && !(addr_hit && data_hit);
`endif

  // Expected-store table; contents survive clear/reset, only the count is zeroed
  always_ff @(posedge clk) begin
    if (ld_accept && !clear) begin
      exp_addr[wr_ptr[IW-1:0]] <= ld_addr;
      exp_data[wr_ptr[IW-1:0]] <= ld_data;
      exp_mask[wr_ptr[IW-1:0]] <= ld_mask;
    end
  end

  // Control FSM, pointers, timeout counter and registered verdict outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      match_cnt <= '0;
      tcnt      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      err_idx   <= '0;
      ld_ovf    <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      match_cnt <= '0;
      tcnt      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      err_idx   <= '0;
      ld_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_accept) begin
            wr_ptr <= wr_ptr + ONE;
          end else if (ld_valid && table_full) begin
            ld_ovf <= 1'b1;
          end
          // a load in the same cycle as start counts toward the non-empty check
          if (start && ((wr_ptr != '0) || ld_accept)) begin
            state     <= S_RUN;
            tcnt      <= '0;
            match_cnt <= '0;
          end
        end
        S_RUN: begin
          // a matching store outranks a timeout expiring in the same cycle
          if (store_hit) begin
            match_cnt <= next_cnt;
            tcnt      <= '0;
            if (next_cnt == wr_ptr) begin
              state <= S_PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end else if (store_bad) begin
            state   <= S_FAIL;
            done    <= 1'b1;
            fail    <= 1'b1;
            err_idx <= rd_idx;
          end else if (tcnt == T_LAST) begin
            state   <= S_FAIL;
            done    <= 1'b1;
            fail    <= 1'b1;
            timeout <= 1'b1;
            err_idx <= rd_idx;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_checker.sv
// Scoreboard bench for store_checker: stimulus pushes expected verdicts into a
// queue, a monitor pops and compares each time done rises.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  memwrite = '0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] ld_mask = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        done, pass, fail, timeout, ld_ovf;
  logic [2:0]  err_idx;
  logic [3:0]  match_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic       p;
    logic       f;
    logic       t;
    logic [2:0] e;
    logic [3:0] m;
    int         c;
  } verdict_t;

  verdict_t exp_q[$];

  store_checker #(
    .ADDR_W(32),
    .DATA_W(32),
    .DEPTH(8),
    .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_mask(ld_mask), .start(start), .clear(clear),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_idx(err_idx), .match_cnt(match_cnt), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: one verdict per rising done
  initial begin
    logic done_q;
    verdict_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_verdict: got p=%0b f=%0b t=%0b err=%0d mc=%0d, required none",
                   pass, fail, timeout, err_idx, match_cnt);
        end else begin
          e = exp_q.pop_front();
          if (pass !== e.p || fail !== e.f || timeout !== e.t || err_idx !== e.e ||
              match_cnt !== e.m || cyc != e.c) begin
            n_fail++;
            $display("FAIL verdict: got p=%0b f=%0b t=%0b err=%0d mc=%0d cyc=%0d, required p=%0b f=%0b t=%0b err=%0d mc=%0d cyc=%0d",
                     pass, fail, timeout, err_idx, match_cnt, cyc, e.p, e.f, e.t, e.e, e.m, e.c);
          end
        end
      end
      done_q = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic p, input logic f, input logic t,
                          input logic [2:0] e, input logic [3:0] m, input int c);
    verdict_t v;
    v.p = p; v.f = f; v.t = t; v.e = e; v.m = m; v.c = c;
    exp_q.push_back(v);
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() > 0; i++) tick();
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s: verdict still pending after %0d cycles, required one", name, limit);
      exp_q.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {20'd0, done, pass, fail, timeout, ld_ovf, err_idx, match_cnt}, 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_mask = m;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
    memwrite = mw; dataadr = a; writedata = d;
    tick();
    memwrite = '0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b1;
    tick();
    check_zero("after_reset_release");

    // single-entry exact match -> pass on the following cycle
    load(32'd84, 32'hFFFF7F02, 32'hFFFFFFFF);
    go();
    expect_v(1, 0, 0, 0, 1, cyc + 1);
    store(2'b01, 32'd84, 32'hFFFF7F02);
    wait_drain("exact_match", 5);
    // stores in PASS are ignored
    store(2'b01, 32'd84, 32'h0);
    check("pass_holds", {29'd0, done, pass, fail}, 32'b110);

    // data mismatch -> fail at index 0
    do_clear();
    check_zero("clear_outputs");
    load(32'd84, 32'hFFFF7F02, 32'hFFFFFFFF);
    go();
    expect_v(0, 1, 0, 0, 0, cyc + 1);
    store(2'b11, 32'd84, 32'hFFFF7F03);
    wait_drain("data_mismatch", 5);

    // store to an unexpected address
    do_clear();
    load(32'd84, 32'h11111111, 32'hFFFFFFFF);
    load(32'd88, 32'h22222222, 32'hFFFFFFFF);
    go();
`ifdef STORE_CHECKER_FILTER_EN
    store(2'b01, 32'd80, 32'h11111111);
    store(2'b01, 32'd84, 32'h11111111);
    expect_v(1, 0, 0, 0, 2, cyc + 1);
    store(2'b01, 32'd88, 32'h22222222);
`else
    expect_v(0, 1, 0, 0, 0, cyc + 1);
    store(2'b01, 32'd80, 32'h11111111);
`endif
    wait_drain("addr_mismatch", 5);

    // no stores -> timeout exactly 16 cycles after start
    do_clear();
    load(32'd84, 32'hFFFF7F02, 32'hFFFFFFFF);
    go();
    expect_v(0, 1, 1, 0, 0, cyc + 16);
    wait_drain("timeout", 30);

    // masked compare ignores upper half
    do_clear();
    load(32'd84, 32'hFFFF7F02, 32'h0000FFFF);
    go();
    expect_v(1, 0, 0, 0, 1, cyc + 1);
    store(2'b10, 32'd84, 32'hABCD7F02);
    wait_drain("masked_match", 5);

    // third entry mismatches -> err_idx 2, two matches counted
    do_clear();
    load(32'h100, 32'hA0, 32'hFFFFFFFF);
    load(32'h104, 32'hA1, 32'hFFFFFFFF);
    load(32'h108, 32'hA2, 32'h000000F0);
    go();
    store(2'b10, 32'h100, 32'hA0);
    store(2'b11, 32'h104, 32'hA1);
    expect_v(0, 1, 0, 2, 2, cyc + 1);
    store(2'b01, 32'h108, 32'hB2);
    wait_drain("third_mismatch", 5);

    // match restarts timeout; match on the expiring cycle still wins
    do_clear();
    load(32'h200, 32'h5, 32'hFFFFFFFF);
    load(32'h204, 32'h6, 32'hFFFFFFFF);
    go();
    repeat (10) tick();
    store(2'b01, 32'h200, 32'h5);
    repeat (15) tick();
    expect_v(1, 0, 0, 0, 2, cyc + 1);
    store(2'b01, 32'h204, 32'h6);
    wait_drain("timeout_restart", 5);

    // stores in IDLE ignored; loads during RUN ignored
    do_clear();
    load(32'h300, 32'h7, 32'hFFFFFFFF);
    store(2'b01, 32'h300, 32'h8);
    tick();
    check("idle_store_ignored", {31'd0, done}, 32'd0);
    go();
    load(32'h304, 32'h9, 32'hFFFFFFFF);
    expect_v(1, 0, 0, 0, 1, cyc + 1);
    store(2'b01, 32'h300, 32'h7);
    wait_drain("run_load_ignored", 5);

    // start with empty table ignored; start with same-cycle load accepted
    do_clear();
    go();
    store(2'b01, 32'h300, 32'h7);
    tick();
    check("empty_start_ignored", {31'd0, done}, 32'd0);
    ld_valid = 1'b1; ld_addr = 32'h400; ld_data = 32'hC; ld_mask = 32'hFFFFFFFF;
    start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    expect_v(1, 0, 0, 0, 1, cyc + 1);
    store(2'b01, 32'h400, 32'hC);
    wait_drain("start_with_load", 5);

    // overflow: ninth load dropped, eight entries checked
    do_clear();
    for (int i = 0; i < 9; i++) load(32'h100 + 4 * i, 32'h1000 + i, 32'hFFFFFFFF);
    check("ld_ovf_set", {31'd0, ld_ovf}, 32'd1);
    go();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_v(1, 0, 0, 0, 8, cyc + 1);
      store(2'b01, 32'h100 + 4 * i, 32'h1000 + i);
    end
    wait_drain("full_table_pass", 5);

    // async reset mid-run clears outputs before the next edge
    do_clear();
    for (int i = 0; i < 9; i++) load(32'h100 + 4 * i, 32'h1000 + i, 32'hFFFFFFFF);
    go();
    for (int i = 0; i < 3; i++) store(2'b01, 32'h100 + 4 * i, 32'h1000 + i);
    check("mid_run_count", {28'd0, match_cnt}, 32'd3);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    tick();
    reset = 1'b1;
    tick();
    go();
    store(2'b01, 32'h100, 32'h1000);
    tick();
    check("count_zero_after_reset", {31'd0, done}, 32'd0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty: got %0d pending, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
